// File: rtl/snn_layer_router_if.sv
// AXI-Stream style spike event channel used on both sides of the layer router.
interface snn_layer_router_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/snn_layer_router.sv
// Spike-stream router and run sequencer for a bank of attached layer engines.
// Streams are steered combinationally to the active slot; only control state is registered.
module snn_layer_router #(
   parameter int unsigned NUM_SLOTS  = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CFG_WORDS  = 8,
   parameter int unsigned CFG_WIDTH  = 32,
   parameter int unsigned TMO_WIDTH  = 20
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   enable,
   snn_layer_router_if.slave                      s_axis,
   snn_layer_router_if.master                     m_axis,
   output logic [NUM_SLOTS*DATA_WIDTH-1:0]        slot_in_tdata,
   output logic [NUM_SLOTS-1:0]                   slot_in_tvalid,
   input  logic [NUM_SLOTS-1:0]                   slot_in_tready,
   output logic [NUM_SLOTS-1:0]                   slot_in_tlast,
   input  logic [NUM_SLOTS*DATA_WIDTH-1:0]        slot_out_tdata,
   input  logic [NUM_SLOTS-1:0]                   slot_out_tvalid,
   output logic [NUM_SLOTS-1:0]                   slot_out_tready,
   input  logic [NUM_SLOTS-1:0]                   slot_out_tlast,
   input  logic [NUM_SLOTS-1:0]                   slot_done,
   output logic [NUM_SLOTS*CFG_WORDS*CFG_WIDTH-1:0] slot_cfg,
   input  logic [3:0]                             cfg_slot,
   input  logic [$clog2(CFG_WORDS):0]             cfg_addr,
   input  logic [CFG_WIDTH-1:0]                   cfg_wdata,
   input  logic                                   cfg_write,
   output logic [CFG_WIDTH-1:0]                   cfg_rdata,
   input  logic [3:0]                             exec_slot,
   input  logic                                   exec_start,
   input  logic [TMO_WIDTH-1:0]                   timeout_limit,
   output logic                                   exec_busy,
   output logic                                   exec_done,
   output logic                                   exec_error,
   output logic [1:0]                             err_code,
   output logic [3:0]                             active_slot,
   output logic [31:0]                            in_count,
   output logic [31:0]                            out_count
);
   localparam int unsigned SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int unsigned WW = (CFG_WORDS > 1) ? $clog2(CFG_WORDS) : 1;
   localparam int unsigned AW = $clog2(CFG_WORDS) + 1;
   localparam int unsigned NW = NUM_SLOTS * CFG_WORDS;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                  state;
   logic [CFG_WIDTH-1:0]    cfg_mem [NW];
   logic [NUM_SLOTS-1:0]    slot_en;
   logic [TMO_WIDTH-1:0]    tmo_cnt;
   logic [TMO_WIDTH-1:0]    tmo_inc;
   logic [SW-1:0]           act;
   logic [SW+WW-1:0]        cfg_idx;
   logic                    cfg_slot_ok;
   logic                    exec_slot_ok;
   logic                    run;
   logic                    route;
   logic                    sel_in_ready;
   logic                    sel_out_valid;
   logic [DATA_WIDTH-1:0]   sel_out_data;
   logic                    sel_out_last;
   logic                    sel_done;
   logic                    in_hs;
   logic                    out_hs;
   logic                    drain_ok;
   logic                    tmo_hit;

   assign act          = active_slot[SW-1:0];
   assign cfg_idx      = {cfg_slot[SW-1:0], cfg_addr[WW-1:0]};
   assign cfg_slot_ok  = {1'b0, cfg_slot} < 5'(NUM_SLOTS);
   assign exec_slot_ok = {1'b0, exec_slot} < 5'(NUM_SLOTS);
   assign run          = (state == RUN);
   assign route        = (state == RUN) || (state == DRAIN);
   assign exec_busy    = route;

   for (genvar i = 0; i < NW; i++) begin : g_cfg_flat
      assign slot_cfg[i*CFG_WIDTH +: CFG_WIDTH] = cfg_mem[i];
   end

   // Steer both streams to/from the active slot; all other slots stay quiet.
   always_comb begin
      slot_in_tdata   = '0;
      slot_in_tvalid  = '0;
      slot_in_tlast   = '0;
      slot_out_tready = '0;
      sel_in_ready    = 1'b0;
      sel_out_valid   = 1'b0;
      sel_out_data    = '0;
      sel_out_last    = 1'b0;
      sel_done        = 1'b0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         if (act == SW'(k)) begin
            sel_in_ready  = slot_in_tready[k];
            sel_out_valid = slot_out_tvalid[k];
            sel_out_data  = slot_out_tdata[k*DATA_WIDTH +: DATA_WIDTH];
            sel_out_last  = slot_out_tlast[k];
            sel_done      = slot_done[k];
            if (run) begin
               slot_in_tvalid[k]                          = s_axis.tvalid;
               slot_in_tdata[k*DATA_WIDTH +: DATA_WIDTH]  = s_axis.tdata;
               slot_in_tlast[k]                           = s_axis.tlast;
            end
            if (route) slot_out_tready[k] = m_axis.tready;
         end
      end
      s_axis.tready = run & sel_in_ready;
      m_axis.tvalid = route & sel_out_valid;
      m_axis.tdata  = route ? sel_out_data : '0;
      m_axis.tlast  = route & sel_out_last;
   end

   assign in_hs    = s_axis.tvalid & s_axis.tready;
   assign out_hs   = m_axis.tvalid & m_axis.tready;
   assign drain_ok = sel_done & (~m_axis.tvalid | m_axis.tready);
   assign tmo_inc  = tmo_cnt + TMO_WIDTH'(1);
   assign tmo_hit  = (timeout_limit != '0) && enable && !in_hs && !out_hs &&
                     (tmo_inc == timeout_limit);

   // Configuration store and registered readback.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NW; i++) cfg_mem[i] <= '0;
         slot_en   <= '0;
         cfg_rdata <= '0;
      end else begin
         if (cfg_write && cfg_slot_ok) begin
            if (cfg_addr[AW-1]) slot_en[cfg_slot[SW-1:0]] <= cfg_wdata[0];
            else                cfg_mem[cfg_idx]          <= cfg_wdata;
         end
         if (!cfg_slot_ok)        cfg_rdata <= '0;
         else if (cfg_addr[AW-1]) cfg_rdata <= CFG_WIDTH'(slot_en[cfg_slot[SW-1:0]]);
         else                     cfg_rdata <= cfg_mem[cfg_idx];
      end
   end

   // Run sequencer: start checks, frame tracking, drain, timeout and statistics.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         active_slot <= '0;
         in_count    <= '0;
         out_count   <= '0;
         err_code    <= '0;
         exec_done   <= 1'b0;
         exec_error  <= 1'b0;
         tmo_cnt     <= '0;
      end else begin
         exec_done  <= 1'b0;
         exec_error <= 1'b0;
         if (in_hs && (in_count != '1))   in_count  <= in_count + 32'd1;
         if (out_hs && (out_count != '1)) out_count <= out_count + 32'd1;
         unique case (state)
            IDLE: begin
               if (exec_start && enable) begin
                  if (!exec_slot_ok) begin
                     exec_error <= 1'b1;
                     err_code   <= 2'd1;
                  end else if (!slot_en[exec_slot[SW-1:0]]) begin
                     exec_error <= 1'b1;
                     err_code   <= 2'd2;
                  end else begin
                     active_slot <= exec_slot;
                     in_count    <= '0;
                     out_count   <= '0;
                     err_code    <= 2'd0;
                     tmo_cnt     <= '0;
                     state       <= RUN;
                  end
               end
            end
            RUN, DRAIN: begin
               if (in_hs || out_hs) tmo_cnt <= '0;
               else if (enable)     tmo_cnt <= tmo_inc;
               if ((state == DRAIN) && drain_ok) begin
                  exec_done <= 1'b1;
                  state     <= DONE;
               end else if (tmo_hit) begin
                  exec_error <= 1'b1;
                  err_code   <= 2'd3;
                  state      <= IDLE;
               end else if (run && in_hs && s_axis.tlast) begin
                  state <= DRAIN;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_snn_layer_router.sv
// Directed self-checking bench for snn_layer_router with 4 slots of 8 config words.
module tb_snn_layer_router;
   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic [127:0]  slot_in_tdata;
   logic [3:0]    slot_in_tvalid;
   logic [3:0]    slot_in_tready;
   logic [3:0]    slot_in_tlast;
   logic [127:0]  slot_out_tdata;
   logic [3:0]    slot_out_tvalid;
   logic [3:0]    slot_out_tready;
   logic [3:0]    slot_out_tlast;
   logic [3:0]    slot_done;
   logic [1023:0] slot_cfg;
   logic [3:0]    cfg_slot;
   logic [3:0]    cfg_addr;
   logic [31:0]   cfg_wdata;
   logic          cfg_write;
   logic [31:0]   cfg_rdata;
   logic [3:0]    exec_slot;
   logic          exec_start;
   logic [19:0]   timeout_limit;
   logic          exec_busy;
   logic          exec_done;
   logic          exec_error;
   logic [1:0]    err_code;
   logic [3:0]    active_slot;
   logic [31:0]   in_count;
   logic [31:0]   out_count;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   snn_layer_router_if #(.DATA_WIDTH(32)) s_if ();
   snn_layer_router_if #(.DATA_WIDTH(32)) m_if ();

   snn_layer_router dut (
      .clk(clk), .reset(reset), .enable(enable),
      .s_axis(s_if), .m_axis(m_if),
      .slot_in_tdata(slot_in_tdata), .slot_in_tvalid(slot_in_tvalid),
      .slot_in_tready(slot_in_tready), .slot_in_tlast(slot_in_tlast),
      .slot_out_tdata(slot_out_tdata), .slot_out_tvalid(slot_out_tvalid),
      .slot_out_tready(slot_out_tready), .slot_out_tlast(slot_out_tlast),
      .slot_done(slot_done), .slot_cfg(slot_cfg),
      .cfg_slot(cfg_slot), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cfg_write(cfg_write), .cfg_rdata(cfg_rdata),
      .exec_slot(exec_slot), .exec_start(exec_start), .timeout_limit(timeout_limit),
      .exec_busy(exec_busy), .exec_done(exec_done), .exec_error(exec_error),
      .err_code(err_code), .active_slot(active_slot),
      .in_count(in_count), .out_count(out_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cfg_wr(input logic [3:0] s, input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      cfg_slot = s; cfg_addr = a; cfg_wdata = d; cfg_write = 1'b1;
      @(negedge clk);
      cfg_write = 1'b0;
   endtask

   task automatic start_run(input logic [3:0] s);
      @(negedge clk);
      exec_slot = s; exec_start = 1'b1;
      @(negedge clk);
      exec_start = 1'b0;
   endtask

   initial begin
      logic [1023:0] exp_cfg;
      logic          seen;
      reset = 1'b1; enable = 1'b0;
      s_if.tdata = '0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0; m_if.tready = 1'b0;
      slot_in_tready = '0; slot_out_tdata = '0; slot_out_tvalid = '0;
      slot_out_tlast = '0; slot_done = '0;
      cfg_slot = '0; cfg_addr = '0; cfg_wdata = '0; cfg_write = 1'b0;
      exec_slot = '0; exec_start = 1'b0; timeout_limit = '0;
      repeat (3) @(negedge clk);
      check("rst_busy",   64'(exec_busy), 64'd0);
      check("rst_err",    64'(err_code), 64'd0);
      check("rst_active", 64'(active_slot), 64'd0);
      check("rst_rdata",  64'(cfg_rdata), 64'd0);
      check("rst_cfg0",   64'(slot_cfg == '0), 64'd1);
      check("rst_sready", 64'(s_if.tready), 64'd0);
      reset = 1'b0; enable = 1'b1;

      // Configuration write, enable, readback; out-of-range slot ignored.
      cfg_wr(4'd2, 4'd3, 32'hDEADBEEF);
      cfg_wr(4'd2, 4'd8, 32'h1);
      cfg_wr(4'd7, 4'd0, 32'h12345678);
      exp_cfg = '0;
      exp_cfg[19*32 +: 32] = 32'hDEADBEEF;
      check("cfg_field",  64'(slot_cfg[19*32 +: 32]), 64'hDEADBEEF);
      check("cfg_ignore", 64'(slot_cfg == exp_cfg), 64'd1);
      @(negedge clk); cfg_slot = 4'd2; cfg_addr = 4'd3;
      @(negedge clk);
      check("cfg_rd_word", 64'(cfg_rdata), 64'hDEADBEEF);
      cfg_addr = 4'd8;
      @(negedge clk);
      check("cfg_rd_en", 64'(cfg_rdata), 64'd1);

      // Normal 5-beat run through slot 2 with echo.
      start_run(4'd2);
      check("run_busy",   64'(exec_busy), 64'd1);
      check("run_active", 64'(active_slot), 64'd2);
      slot_in_tready = 4'b0100;
      for (int i = 0; i < 5; i++) begin
         s_if.tvalid = 1'b1; s_if.tdata = 32'(100 + i); s_if.tlast = (i == 4);
         #1;
         check("in_valid", 64'(slot_in_tvalid), 64'h4);
         check("in_data",  64'(slot_in_tdata[64 +: 32]), 64'(100 + i));
         check("in_ready", 64'(s_if.tready), 64'd1);
         @(negedge clk);
      end
      s_if.tvalid = 1'b0; s_if.tlast = 1'b0; slot_in_tready = '0;
      m_if.tready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         slot_out_tvalid = 4'b0100; slot_out_tdata[64 +: 32] = 32'(200 + i);
         slot_out_tlast = (i == 4) ? 4'b0100 : 4'b0000;
         #1;
         check("drain_sready", 64'(s_if.tready), 64'd0);
         check("out_data",     64'(m_if.tdata), 64'(200 + i));
         check("out_oready",   64'(slot_out_tready), 64'h4);
         check("out_done_lo",  64'(exec_done), 64'd0);
         @(negedge clk);
      end
      slot_out_tvalid = '0; slot_out_tlast = '0; slot_done = 4'b0100;
      @(negedge clk);
      check("done_pulse", 64'(exec_done), 64'd1);
      check("done_busy",  64'(exec_busy), 64'd0);
      slot_done = '0;
      @(negedge clk);
      check("done_once", 64'(exec_done), 64'd0);
      check("in_count",  64'(in_count), 64'd5);
      check("out_count", 64'(out_count), 64'd5);

      // Rejected starts: bad slot, disabled slot, globally disabled.
      start_run(4'd7);
      check("bad_err",   64'(exec_error), 64'd1);
      check("bad_code",  64'(err_code), 64'd1);
      check("bad_busy",  64'(exec_busy), 64'd0);
      check("bad_keep",  64'(active_slot), 64'd2);
      @(negedge clk);
      check("bad_once",  64'(exec_error), 64'd0);
      check("bad_hold",  64'(err_code), 64'd1);
      start_run(4'd1);
      check("dis_err",   64'(exec_error), 64'd1);
      check("dis_code",  64'(err_code), 64'd2);
      enable = 1'b0;
      start_run(4'd2);
      check("gen_busy",  64'(exec_busy), 64'd0);
      check("gen_err",   64'(exec_error), 64'd0);
      check("gen_code",  64'(err_code), 64'd2);
      enable = 1'b1;

      // Timeout: engine stalls after two beats.
      timeout_limit = 20'd10;
      start_run(4'd2);
      check("tmo_code_clr", 64'(err_code), 64'd0);
      slot_in_tready = 4'b0100;
      s_if.tvalid = 1'b1; s_if.tdata = 32'hA0; s_if.tlast = 1'b0;
      @(negedge clk);
      s_if.tdata = 32'hA1;
      @(negedge clk);
      slot_in_tready = '0;
      seen = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         seen = seen | exec_error;
      end
      check("tmo_early", 64'(seen), 64'd0);
      @(negedge clk);
      check("tmo_err",   64'(exec_error), 64'd1);
      check("tmo_code",  64'(err_code), 64'd3);
      check("tmo_busy",  64'(exec_busy), 64'd0);
      check("tmo_count", 64'(in_count), 64'd2);
      s_if.tvalid = 1'b0;
      timeout_limit = '0;

      // Pending output beat blocks completion even with done high.
      start_run(4'd2);
      slot_in_tready = 4'b0100;
      s_if.tvalid = 1'b1; s_if.tdata = 32'hB0; s_if.tlast = 1'b1;
      @(negedge clk);
      s_if.tvalid = 1'b0; s_if.tlast = 1'b0; slot_in_tready = '0;
      m_if.tready = 1'b0;
      slot_out_tvalid = 4'b0100; slot_out_tdata[64 +: 32] = 32'hC0DE;
      slot_out_tlast = 4'b0100; slot_done = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_busy", 64'(exec_busy), 64'd1);
         check("bp_done", 64'(exec_done), 64'd0);
         check("bp_data", 64'(m_if.tdata), 64'hC0DE);
      end
      m_if.tready = 1'b1;
      @(negedge clk);
      slot_out_tvalid = '0; slot_out_tlast = '0; slot_done = '0;
      check("bp_done_pulse", 64'(exec_done), 64'd1);
      check("bp_out_count",  64'(out_count), 64'd1);

      // Reset in the middle of a run.
      start_run(4'd2);
      slot_in_tready = 4'b0100;
      s_if.tvalid = 1'b1; s_if.tdata = 32'hD0; s_if.tlast = 1'b0;
      @(negedge clk);
      check("pre_rst_cnt", 64'(in_count), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mrst_busy",   64'(exec_busy), 64'd0);
      check("mrst_cnt",    64'(in_count), 64'd0);
      check("mrst_active", 64'(active_slot), 64'd0);
      check("mrst_valid",  64'(slot_in_tvalid), 64'd0);
      check("mrst_sready", 64'(s_if.tready), 64'd0);
      check("mrst_pulses", 64'({exec_done, exec_error}), 64'd0);
      check("mrst_cfg",    64'(slot_cfg == '0), 64'd1);
      s_if.tvalid = 1'b0;
      @(negedge clk);
      check("mrst_nopulse", 64'({exec_done, exec_error}), 64'd0);
      cfg_wr(4'd2, 4'd8, 32'h1);
      start_run(4'd2);
      check("rst_restart_busy",   64'(exec_busy), 64'd1);
      check("rst_restart_active", 64'(active_slot), 64'd2);
      s_if.tvalid = 1'b1; s_if.tdata = 32'hE0; s_if.tlast = 1'b1;
      @(negedge clk);
      s_if.tvalid = 1'b0; s_if.tlast = 1'b0; slot_in_tready = '0;
      slot_done = 4'b0100;
      @(negedge clk);
      check("rst_restart_done", 64'(exec_done), 64'd1);
      slot_done = '0;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
